maxpool2d_param: RTL

Parametrised 2-D pooling engine, the successor to the fixed 2x2/stride-2 pool layers in the CIFAR-10 CNN accelerator chain. It reads an upstream layer's activation memory over a 1-cycle-latency read port and pools each K x K window at stride S. Max or average mode is selected per run. Results are packed PACK-per-word into an internal output RAM, which the next layer reads through a 1-cycle-latency port. Unlike the previous pool layers, it does not instantiate the upstream layer; the top level starts the upstream layer and then starts this block.

---
 rtl/maxpool_pkg.sv | 43 ++++
 rtl/pool_out_ram.sv | 32 +++
 rtl/maxpool2d_param.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared types and elaboration-time helpers for the 2-D pooling
// engine. Holds the FSM state enum, the pooling mode enum and constant
// functions that derive the output geometry and datapath widths from the
// top-level parameters.
package maxpool_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      REDUCE = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_t;

   // Output extent of one spatial dimension for a K-wide window at stride S.
   function automatic int out_dim(input int in_n, input int k, input int s);
      return (in_n - k) / s + 1;
   endfunction

   function automatic int n_out_f(input int ch, input int h, input int w,
                                  input int k, input int s);
      return ch * out_dim(h, k, s) * out_dim(w, k, s);
   endfunction

   function automatic int n_words_f(input int n, input int pack);
      return (n + pack - 1) / pack;
   endfunction

   // Sum of K*K values of dw bits never overflows dw + clog2(K*K) bits.
   function automatic int acc_w_f(input int dw, input int k);
      return dw + $clog2(k * k);
   endfunction

   // Index width for a counter over n values; at least one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pool_out_ram.sv
// pool_out_ram: simple dual-port RAM holding packed pooling results.
//   clk   : clock
//   we    : write enable, port A (synchronous write)
//   waddr : word address, port A
//   wdata : word data, port A
//   raddr : word address, port B
//   rdata : registered read data, port B (1-cycle latency). A read of the
//           word being written in the same cycle returns the old contents.
module pool_out_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/maxpool2d_param.sv
// maxpool2d_param: parametrised K x K / stride S max- or average-pooling
// engine. Reads an upstream activation memory (1-cycle read latency), pools
// every window and packs PACK results per word into an internal output RAM.
//   clk, resetn : clock, asynchronous active-low reset
//   start, mode : run request (honoured in IDLE) and pool mode (0 max, 1 avg)
//   busy, done  : run in progress / single-cycle completion pulse
//   src_en, src_addr, src_data : upstream read port, data one cycle after en
//   rd_addr, rd_data           : output element read port, 1-cycle latency
module maxpool2d_param
   import maxpool_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int IN_H   = 8,
   parameter int IN_W   = 8,
   parameter int CH     = 128,
   parameter int K      = 2,
   parameter int S      = 2,
   parameter int PACK   = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic              src_en,
   output logic [31:0]       src_addr,
   input  logic [DATA_W-1:0] src_data,
   input  logic [31:0]       rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int OUT_H   = out_dim(IN_H, K, S);
   localparam int OUT_W   = out_dim(IN_W, K, S);
   localparam int N_OUT   = n_out_f(CH, IN_H, IN_W, K, S);
   localparam int N_WORDS = n_words_f(N_OUT, PACK);
   localparam int KK      = K * K;
   localparam int ACC_W   = acc_w_f(DATA_W, K);
   localparam int WORD_W  = PACK * DATA_W;
   localparam int AW      = idx_w(N_WORDS);
   localparam int CH_W    = idx_w(CH);
   localparam int OH_W    = idx_w(OUT_H);
   localparam int OW_W    = idx_w(OUT_W);
   localparam int K_W     = idx_w(K);
   localparam int LN_W    = idx_w(PACK);

   state_t     state_q, state_nx;
   pool_mode_t mode_q;

   logic [CH_W-1:0]  ch_q;
   logic [OH_W-1:0]  orow_q;
   logic [OW_W-1:0]  ocol_q;
   logic [K_W-1:0]   kr_q, kc_q;
   logic [LN_W-1:0]  lane_q;
   logic [AW-1:0]    word_q;
   logic [ACC_W-1:0] acc_q, acc_fold;
   logic             src_vld_q;
   logic [DATA_W-1:0] result;
   logic             last_tap, last_win, we;
   logic [PACK-1:0][DATA_W-1:0] stage_q, stage_nx, rword;
   logic [LN_W-1:0]  rd_lane_q;

   assign last_tap = (kr_q == K_W'(K - 1)) && (kc_q == K_W'(K - 1));
   assign last_win = (ch_q == CH_W'(CH - 1)) && (orow_q == OH_W'(OUT_H - 1)) &&
                     (ocol_q == OW_W'(OUT_W - 1));

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_nx;
   end

   // FSM next state and decoded outputs
   always_comb begin
      state_nx = state_q;
      busy     = 1'b0;
      done     = 1'b0;
      src_en   = 1'b0;
      unique case (state_q)
         IDLE:   if (start) state_nx = FETCH;
         FETCH: begin
            busy   = 1'b1;
            src_en = 1'b1;
            if (last_tap) state_nx = REDUCE;
         end
         REDUCE: begin
            busy     = 1'b1;
            state_nx = last_win ? DONE : FETCH;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign src_addr = 32'(ch_q) * 32'(IN_H * IN_W)
                   + (32'(orow_q) * 32'(S) + 32'(kr_q)) * 32'(IN_W)
                   + 32'(ocol_q) * 32'(S) + 32'(kc_q);

   // Fold the datum returning this cycle into the running max / sum. The
   // accumulator is zeroed between windows, so zero is a valid max seed.
   always_comb begin
      if (mode_q == POOL_AVG)
         acc_fold = acc_q + ACC_W'(src_data);
      else
         acc_fold = (ACC_W'(src_data) > acc_q) ? ACC_W'(src_data) : acc_q;
   end

   // Constant divisor; reduces to a shift when K*K is a power of two.
   assign result = (mode_q == POOL_AVG) ? DATA_W'(acc_fold / ACC_W'(KK))
                                        : DATA_W'(acc_fold);

   // Lane 0 sits in the MSBs of the word.
   always_comb begin
      stage_nx = stage_q;
      for (int l = 0; l < PACK; l++)
         if (lane_q == LN_W'(l)) stage_nx[PACK-1-l] = result;
   end

   assign we = (state_q == REDUCE) && ((lane_q == LN_W'(PACK - 1)) || last_win);

   // Window counters, accumulator and word staging
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mode_q    <= POOL_MAX;
         ch_q      <= '0;
         orow_q    <= '0;
         ocol_q    <= '0;
         kr_q      <= '0;
         kc_q      <= '0;
         lane_q    <= '0;
         word_q    <= '0;
         acc_q     <= '0;
         stage_q   <= '0;
         src_vld_q <= 1'b0;
      end else begin
         src_vld_q <= src_en;
         unique case (state_q)
            IDLE: if (start) begin
               mode_q  <= pool_mode_t'(mode);
               ch_q    <= '0;
               orow_q  <= '0;
               ocol_q  <= '0;
               kr_q    <= '0;
               kc_q    <= '0;
               lane_q  <= '0;
               word_q  <= '0;
               acc_q   <= '0;
               stage_q <= '0;
            end
            FETCH: begin
               if (src_vld_q) acc_q <= acc_fold;
               if (kc_q == K_W'(K - 1)) begin
                  kc_q <= '0;
                  kr_q <= (kr_q == K_W'(K - 1)) ? '0 : kr_q + 1'b1;
               end else begin
                  kc_q <= kc_q + 1'b1;
               end
            end
            REDUCE: begin
               acc_q <= '0;
               if (we) begin
                  stage_q <= '0;
                  lane_q  <= '0;
                  word_q  <= word_q + 1'b1;
               end else begin
                  stage_q <= stage_nx;
                  lane_q  <= lane_q + 1'b1;
               end
               if (ocol_q == OW_W'(OUT_W - 1)) begin
                  ocol_q <= '0;
                  if (orow_q == OH_W'(OUT_H - 1)) begin
                     orow_q <= '0;
                     ch_q   <= ch_q + 1'b1;
                  end else begin
                     orow_q <= orow_q + 1'b1;
                  end
               end else begin
                  ocol_q <= ocol_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Lane select is applied after the RAM's registered read, so the lane
   // index is delayed to line up with the returned word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rd_lane_q <= '0;
      else         rd_lane_q <= LN_W'(rd_addr % 32'(PACK));
   end

   pool_out_ram #(
      .WIDTH (WORD_W),
      .DEPTH (N_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (word_q),
      .wdata (stage_nx),
      .raddr (AW'(rd_addr / 32'(PACK))),
      .rdata (rword)
   );

   always_comb begin
      rd_data = '0;
      for (int l = 0; l < PACK; l++)
         if (rd_lane_q == LN_W'(l)) rd_data = rword[PACK-1-l];
   end

endmodule
